// File: rtl/axis_pgroup_dispatcher.sv
// AXI-Stream pixel-group dispatcher: a 2-entry input skid, a TDEST route lock,
// per-processor FIFOs and a saturating count of packets with a bad destination.
module axis_pgroup_dispatcher #(
  parameter int IP_AMT          = 4,
  parameter int IP_DATA_W       = 256,
  parameter int AXIS_TID_W      = 2,
  parameter int AXIS_TDEST_W    = 4,
  parameter int AXIS_TDEST_BASE = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TID_W-1:0]       s_tid_i,
  input  logic [AXIS_TDEST_W-1:0]     s_tdest_i,
  input  logic [IP_DATA_W-1:0]        s_tdata_i,
  input  logic                        s_tlast_i,
  input  logic                        s_tvalid_i,
  output logic                        s_tready_o,
  output logic [IP_AMT*IP_DATA_W-1:0] pgroup_o,
  output logic [IP_AMT-1:0]           pgroup_last_o,
  output logic [IP_AMT-1:0]           pgroup_valid_o,
  input  logic [IP_AMT-1:0]           pgroup_ready_i,
  output logic [DROP_CNT_W-1:0]       drop_cnt_o,
  output logic [IP_AMT-1:0]           fifo_full_o
);

  localparam int IDX_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [AXIS_TDEST_W-1:0] BASE = AXIS_TDEST_BASE[AXIS_TDEST_W-1:0];

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        lockIdx_q, lockIdx_d;
  logic [DROP_CNT_W-1:0]   dropCnt_q, dropCnt_d;
  logic                    dropPkt;

  logic [1:0]              skidCnt_q, skidCnt_d;
  logic [IP_DATA_W-1:0]    skidData_q [2];
  logic [AXIS_TDEST_W-1:0] skidDest_q [2];
  logic [1:0]              skidLast_q;
  logic                    tready_q;

  logic                    push, headPop, headValid, headInRange;
  logic [AXIS_TDEST_W-1:0] headOffset;
  logic [IDX_W-1:0]        headIdx;

  logic [IP_AMT-1:0]       fifoEmpty, fifoFull, fifoPop, canWrite, wrEn;

  // TID travels with the stream but plays no part in routing.
  logic unusedTid;
  assign unusedTid = ^s_tid_i;

  assign push        = s_tvalid_i & tready_q;
  assign headValid   = (skidCnt_q != 2'd0);
  assign headOffset  = skidDest_q[0] - BASE;
  assign headInRange = (skidDest_q[0] >= BASE) && (int'(headOffset) < IP_AMT);
  assign headIdx     = headOffset[IDX_W-1:0];
  assign skidCnt_d   = skidCnt_q + {1'b0, push} - {1'b0, headPop};

  always_ff @(posedge clk) begin
    if (rst) begin
      skidCnt_q <= 2'd0;
      tready_q  <= 1'b0;
    end else begin
      skidCnt_q <= skidCnt_d;
      tready_q  <= (skidCnt_d != 2'd2);
    end
  end

  // A new beat lands behind whatever survives this cycle's pop.
  always_ff @(posedge clk) begin
    if (headPop) begin
      skidData_q[0] <= skidData_q[1];
      skidDest_q[0] <= skidDest_q[1];
      skidLast_q[0] <= skidLast_q[1];
    end
    if (push) begin
      if (skidCnt_q == {1'b0, headPop}) begin
        skidData_q[0] <= s_tdata_i;
        skidDest_q[0] <= s_tdest_i;
        skidLast_q[0] <= s_tlast_i;
      end else begin
        skidData_q[1] <= s_tdata_i;
        skidDest_q[1] <= s_tdest_i;
        skidLast_q[1] <= s_tlast_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lockIdx_q <= '0;
      dropCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lockIdx_q <= lockIdx_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // Out-of-range heads are discarded even in IDLE so a bad packet never stalls the input.
  always_comb begin
    state_d   = state_q;
    lockIdx_d = lockIdx_q;
    dropCnt_d = dropCnt_q;
    dropPkt   = 1'b0;
    headPop   = 1'b0;
    wrEn      = '0;
    case (state_q)
      IDLE: begin
        if (headValid) begin
          if (headInRange) begin
            if (canWrite[headIdx]) begin
              headPop       = 1'b1;
              wrEn[headIdx] = 1'b1;
              if (!skidLast_q[0]) begin
                state_d   = ROUTE;
                lockIdx_d = headIdx;
              end
            end
          end else begin
            headPop = 1'b1;
            if (skidLast_q[0]) dropPkt = 1'b1;
            else state_d = DROP;
          end
        end
      end
      ROUTE: begin
        if (headValid && canWrite[lockIdx_q]) begin
          headPop         = 1'b1;
          wrEn[lockIdx_q] = 1'b1;
          if (skidLast_q[0]) state_d = IDLE;
        end
      end
      DROP: begin
        if (headValid) begin
          headPop = 1'b1;
          if (skidLast_q[0]) begin
            dropPkt = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (dropPkt && (dropCnt_q != '1)) dropCnt_d = dropCnt_q + 1'b1;
  end

  for (genvar g = 0; g < IP_AMT; g++) begin : gFifo
    logic [PTR_W:0]       wrPtr_q, rdPtr_q;
    logic [IP_DATA_W-1:0] memData_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] memLast_q;

    assign fifoEmpty[g] = (wrPtr_q == rdPtr_q);
    assign fifoFull[g]  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                          (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign fifoPop[g]   = pgroup_ready_i[g] & ~fifoEmpty[g];
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign canWrite[g]  = ~fifoFull[g] | fifoPop[g];

    assign pgroup_o[g*IP_DATA_W +: IP_DATA_W] =
      fifoEmpty[g] ? '0 : memData_q[rdPtr_q[PTR_W-1:0]];
    assign pgroup_last_o[g] = ~fifoEmpty[g] & memLast_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (wrEn[g])    wrPtr_q <= wrPtr_q + 1'b1;
        if (fifoPop[g]) rdPtr_q <= rdPtr_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wrEn[g]) begin
        memData_q[wrPtr_q[PTR_W-1:0]] <= skidData_q[0];
        memLast_q[wrPtr_q[PTR_W-1:0]] <= skidLast_q[0];
      end
    end
  end

  assign s_tready_o     = tready_q;
  assign pgroup_valid_o = ~fifoEmpty;
  assign fifo_full_o    = fifoFull;
  assign drop_cnt_o     = dropCnt_q;

endmodule

// File: tb/tb_axis_pgroup_dispatcher.sv
// Scoreboard bench for axis_pgroup_dispatcher: packets are routed by a per-destination
// queue model, and a monitor compares every popped beat against those queues.
module tb_axis_pgroup_dispatcher;

  localparam int IP_AMT    = 4;
  localparam int IP_DATA_W = 256;
  localparam int TID_W     = 2;
  localparam int TDEST_W   = 4;
  localparam int BASE      = 1;
  localparam int DEPTH     = 4;
  localparam int DROP_W    = 16;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [TID_W-1:0]            s_tid_i = '0;
  logic [TDEST_W-1:0]          s_tdest_i = '0;
  logic [IP_DATA_W-1:0]        s_tdata_i = '0;
  logic                        s_tlast_i = 1'b0;
  logic                        s_tvalid_i = 1'b0;
  logic                        s_tready_o;
  logic [IP_AMT*IP_DATA_W-1:0] pgroup_o;
  logic [IP_AMT-1:0]           pgroup_last_o;
  logic [IP_AMT-1:0]           pgroup_valid_o;
  logic [IP_AMT-1:0]           pgroup_ready_i = '0;
  logic [DROP_W-1:0]           drop_cnt_o;
  logic [IP_AMT-1:0]           fifo_full_o;

  axis_pgroup_dispatcher #(
    .IP_AMT(IP_AMT), .IP_DATA_W(IP_DATA_W), .AXIS_TID_W(TID_W), .AXIS_TDEST_W(TDEST_W),
    .AXIS_TDEST_BASE(BASE), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tid_i(s_tid_i), .s_tdest_i(s_tdest_i), .s_tdata_i(s_tdata_i),
    .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .pgroup_o(pgroup_o), .pgroup_last_o(pgroup_last_o), .pgroup_valid_o(pgroup_valid_o),
    .pgroup_ready_i(pgroup_ready_i), .drop_cnt_o(drop_cnt_o), .fifo_full_o(fifo_full_o)
  );

  always #5 clk = ~clk;

  logic [IP_DATA_W:0] expQ [IP_AMT][$];
  logic [IP_DATA_W:0] expBeat;
  int checks = 0;
  int errors = 0;
  int readyMode = 0;
  int dropExp = 0;
  bit stallSeen = 1'b0;

  task automatic checkOutput(input string name, input logic [IP_DATA_W:0] actual,
                             input logic [IP_DATA_W:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Reference routing rule: destination relative to BASE, must land on a real processor.
  function automatic int idxOf(input int dest);
    return (dest >= BASE && (dest - BASE) < IP_AMT) ? dest - BASE : -1;
  endfunction

  function automatic int totalPending();
    int n = 0;
    for (int i = 0; i < IP_AMT; i++) n += expQ[i].size();
    return n;
  endfunction

  function automatic logic [IP_DATA_W-1:0] mkData(input int tag, input int b);
    logic [IP_DATA_W-1:0] d;
    for (int w = 0; w < IP_DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    d[15:0] = 16'(tag * 16 + b);
    return d;
  endfunction

  // Processor-side ready: held low, held high, or random per cycle.
  initial forever begin
    @(negedge clk);
    case (readyMode)
      0:       pgroup_ready_i = '0;
      1:       pgroup_ready_i = '1;
      default: pgroup_ready_i = 4'($urandom);
    endcase
  end

  // Monitor: every transfer on a processor port must match that destination's queue head.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      for (int i = 0; i < IP_AMT; i++) begin
        if (pgroup_valid_o[i] && pgroup_ready_i[i]) begin
          checkOutput($sformatf("pop%0dExpected", i), 257'(expQ[i].size() > 0), 257'(1));
          if (expQ[i].size() > 0) begin
            expBeat = expQ[i].pop_front();
            checkOutput($sformatf("pop%0dBeat", i),
                        {pgroup_last_o[i], pgroup_o[i*IP_DATA_W +: IP_DATA_W]}, expBeat);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one beat from a negedge; returns at the negedge after it was accepted.
  task automatic sendBeat(input int dest, input logic [IP_DATA_W-1:0] data,
                          input logic last, input int expIdx);
    int waited = 0;
    s_tdest_i  = TDEST_W'(dest);
    s_tdata_i  = data;
    s_tlast_i  = last;
    s_tid_i    = TID_W'($urandom);
    s_tvalid_i = 1'b1;
    #1;
    while (!s_tready_o && waited < 300) begin
      stallSeen = 1'b1;
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("sendAccept", 257'(s_tready_o), 257'(1));
    if (s_tready_o && expIdx >= 0) expQ[expIdx].push_back({last, data});
    @(negedge clk);
    s_tvalid_i = 1'b0;
  endtask

  task automatic applyReset();
    rst        = 1'b1;
    s_tvalid_i = 1'b1;
    s_tlast_i  = 1'b0;
    s_tdest_i  = TDEST_W'($urandom);
    for (int i = 0; i < IP_AMT; i++) expQ[i].delete();
    dropExp = 0;
    repeat (3) @(negedge clk);
    checkOutput("rstTready", 257'(s_tready_o), 257'(0));
    checkOutput("rstValid", 257'(pgroup_valid_o), 257'(0));
    checkOutput("rstLast", 257'(pgroup_last_o), 257'(0));
    checkOutput("rstDataZero", 257'(pgroup_o != '0), 257'(0));
    checkOutput("rstDropCnt", 257'(drop_cnt_o), 257'(0));
    checkOutput("rstFull", 257'(fifo_full_o), 257'(0));
    rst        = 1'b0;
    s_tvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("rstReleaseTready", 257'(s_tready_o), 257'(1));
  endtask

  // One packet; the route follows its first beat, abortAfter>=0 resets mid-packet.
  task automatic applyStimulus(input int firstDest, input int nBeats, input int changeAt,
                               input int changeDest, input int abortAfter, input int tag,
                               input bit gaps);
    int idx = idxOf(firstDest);
    for (int b = 0; b < nBeats; b++) begin
      if (b == abortAfter) begin
        applyReset();
        return;
      end
      sendBeat((b >= changeAt) ? changeDest : firstDest, mkData(tag, b), b == nBeats - 1, idx);
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    end
    if (idx < 0) dropExp++;
  endtask

  task automatic drainAll(input string name);
    readyMode = 1;
    for (int c = 0; c < 300; c++) begin
      if (totalPending() == 0 && pgroup_valid_o == '0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checkOutput({name, "Drained"}, 257'(totalPending()), 257'(0));
    checkOutput({name, "ValidIdle"}, 257'(pgroup_valid_o), 257'(0));
  endtask

  int accepted;
  logic [IP_DATA_W-1:0] t5Data [8];
  int badList [4] = '{0, 5, 6, 15};

  initial begin
    // T1: reset with valid held high
    applyReset();

    // T2: 3-beat packet to tdest 3 lands in FIFO 2 two edges after the first accept
    readyMode = 0;
    sendBeat(3, 256'hA0, 1'b0, 2);
    checkOutput("t2ValidNotYet", 257'(pgroup_valid_o), 257'(0));
    sendBeat(3, 256'hA1, 1'b0, 2);
    checkOutput("t2ValidRise", 257'(pgroup_valid_o), 257'(4'b0100));
    sendBeat(3, 256'hA2, 1'b1, 2);
    repeat (2) @(negedge clk);
    checkOutput("t2OnlyFifo2", 257'(pgroup_valid_o), 257'(4'b0100));
    checkOutput("t2HeadData", 257'(pgroup_o[2*IP_DATA_W +: IP_DATA_W]), 257'(256'hA0));
    checkOutput("t2HeadLast", 257'(pgroup_last_o), 257'(0));
    drainAll("t2");

    // T3: tdest changes mid-packet, the lock keeps every beat in FIFO 1
    readyMode = 0;
    applyStimulus(2, 4, 2, 4, -1, 3, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t3Valid", 257'(pgroup_valid_o), 257'(4'b0010));
    checkOutput("t3Full", 257'(fifo_full_o), 257'(4'b0010));
    drainAll("t3");

    // T4: out-of-range packets are drained without backpressure
    readyMode = 0;
    stallSeen = 1'b0;
    applyStimulus(0, 2, 9, 0, -1, 4, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t4DropOne", 257'(drop_cnt_o), 257'(dropExp));
    applyStimulus(5, 2, 9, 0, -1, 5, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t4DropTwo", 257'(drop_cnt_o), 257'(dropExp));
    checkOutput("t4DropIsTwo", 257'(drop_cnt_o), 257'(2));
    checkOutput("t4NoStall", 257'(stallSeen), 257'(0));
    checkOutput("t4NoValid", 257'(pgroup_valid_o), 257'(0));

    // T5: FIFO 0 blocked, input must stall after FIFO plus skid fill up
    readyMode = 0;
    accepted = 0;
    for (int i = 0; i < 8; i++) t5Data[i] = mkData(6, i);
    for (int i = 0; i < 8; i++) begin
      s_tdest_i  = TDEST_W'(1);
      s_tdata_i  = t5Data[i];
      s_tlast_i  = (i == 7);
      s_tvalid_i = 1'b1;
      #1;
      if (!s_tready_o) break;
      expQ[0].push_back({s_tlast_i, t5Data[i]});
      accepted++;
      @(negedge clk);
    end
    s_tvalid_i = 1'b0;
    checkOutput("t5AcceptsBounded", 257'(accepted <= 6), 257'(1));
    checkOutput("t5TreadyLow", 257'(s_tready_o), 257'(0));
    checkOutput("t5Full", 257'(fifo_full_o), 257'(4'b0001));
    readyMode = 1;
    for (int i = accepted; i < 8; i++) sendBeat(1, t5Data[i], i == 7, 0);
    drainAll("t5");

    // T6: random packets, random ready, with a reset in the middle of one packet
    readyMode = 2;
    for (int p = 0; p < 60; p++) begin
      int dest;
      int nb;
      int changeAt;
      int abortAfter;
      dest       = ($urandom_range(0, 4) == 0) ? badList[$urandom_range(0, 3)]
                                               : int'($urandom_range(1, 4));
      nb         = (p == 30) ? int'($urandom_range(2, 6)) : int'($urandom_range(1, 6));
      changeAt   = $urandom_range(1, nb);
      abortAfter = (p == 30) ? int'($urandom_range(1, nb - 1)) : -1;
      applyStimulus(dest, nb, changeAt, $urandom_range(0, 15), abortAfter, p, 1'b1);
    end
    drainAll("t6");
    checkOutput("t6DropCnt", 257'(drop_cnt_o), 257'(dropExp));

    applyReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
